// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the scratch RAM.
package ram_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 5;
    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef logic [ADDR_WIDTH_DEFAULT-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/ram.sv
// Single-port synchronous scratch RAM with a registered read port.
// Reset clears every word as well as the read register.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    // Full clear on reset rules out block-RAM mapping; the array lives in flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else if (wena) begin
            mem_q[addr] <= data_in;
        end else begin
            data_out_q <= mem_q[addr];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_ram;
    import ram_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  wena;
    addr_t addr;
    word_t data_in;
    word_t data_out;

    int checks   = 0;
    int failures = 0;

    word_t model_mem [32];
    word_t model_out;

    always #5 clk = ~clk;

    ram dut (
        .clk      (clk),
        .rst      (rst),
        .wena     (wena),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; the model is updated from the cycle's rules
    // and data_out is compared to the model shortly after the edge.
    task automatic step(input logic r, input logic w, input addr_t a,
                        input word_t d, input string tag);
        @(negedge clk);
        rst     = r;
        wena    = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        if (r) begin
            foreach (model_mem[i]) model_mem[i] = 8'h00;
            model_out = 8'h00;
        end else if (w) begin
            model_mem[a] = d;
        end else begin
            model_out = model_mem[a];
        end
        #1;
        check(tag, data_out, model_out);
    endtask

    task automatic wr(input addr_t a, input word_t d);
        step(1'b0, 1'b1, a, d, "write_hold");
    endtask

    task automatic rd(input addr_t a);
        step(1'b0, 1'b0, a, 8'h00, "read_model");
    endtask

    initial begin
        rst = 1'b1; wena = 1'b0; addr = '0; data_in = '0;

        step(1'b1, 1'b0, 5'h00, 8'h00, "reset_init");
        check("reset_out", data_out, 8'h00);

        // Write then read
        wr(5'h12, 8'h9F);
        wr(5'h02, 8'hFF);
        rd(5'h12); check("rd_12", data_out, 8'h9F);
        rd(5'h02); check("rd_02", data_out, 8'hFF);

        // Output holds through a write
        rd(5'h12); check("rd_12_again", data_out, 8'h9F);
        wr(5'h07, 8'h55); check("hold_on_write", data_out, 8'h9F);
        rd(5'h07); check("rd_07", data_out, 8'h55);

        // Fill, then reset clears everything
        for (int a = 0; a < 32; a++) wr(addr_t'(a), word_t'(a) ^ 8'hA5);
        rd(5'h0B); check("rd_fill_0b", data_out, 8'h0B ^ 8'hA5);
        step(1'b1, 1'b0, 5'h00, 8'h00, "reset_mid");
        check("reset_clears_out", data_out, 8'h00);
        for (int a = 0; a < 32; a++) begin
            rd(addr_t'(a));
            check("rd_after_reset", data_out, 8'h00);
        end

        // Reset beats write
        step(1'b1, 1'b1, 5'h05, 8'h3C, "reset_with_write");
        rd(5'h05); check("reset_beats_write", data_out, 8'h00);

        // Boundary and isolation
        wr(5'h00, 8'h01);
        wr(5'h1F, 8'h80);
        rd(5'h00); check("rd_00", data_out, 8'h01);
        rd(5'h1F); check("rd_1f", data_out, 8'h80);
        rd(5'h01); check("rd_01_iso", data_out, 8'h00);
        rd(5'h1E); check("rd_1e_iso", data_out, 8'h00);

        // Back-to-back write then read
        wr(5'h10, 8'hC3);
        rd(5'h10); check("b2b_10", data_out, 8'hC3);

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            logic  r;
            logic  w;
            addr_t a;
            word_t d;
            r = ($urandom_range(0, 39) == 0);
            w = $urandom_range(0, 1) == 1;
            a = addr_t'($urandom_range(0, 31));
            d = word_t'($urandom);
            step(r, w, a, d, "random");
        end

        // Final sweep of the whole array against the model
        for (int a = 0; a < 32; a++) rd(addr_t'(a));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
